// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, frame constants and bit-timer sizing helper
package uart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_WAIT   = 3'd1;
  localparam state_t S_START  = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_PARITY = 3'd4;
  localparam state_t S_STOP   = 3'd5;
  localparam int UART_DATA_BITS = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: FIFO read-port bundle between the byte FIFO and the UART drain
interface uart_tx_fifo_drain_if;
  import uart_pkg::*;
  logic                      fifo_rd_en;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_empty;
  modport master(output fifo_rd_en, input fifo_rd_data, input fifo_empty);
  modport slave(input fifo_rd_en, output fifo_rd_data, output fifo_empty);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit
module uart_bit_timer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == LAST;
  always_comb cnt_d = (clr || bit_end) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from the FIFO read port and serialises them as UART frames
module uart_tx_fifo_drain import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 0,
  parameter bit PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_en,
  uart_tx_fifo_drain_if.master        fifo,
  output logic                        uart_tx,
  output logic                        busy,
  output logic                        byte_done
);
  state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;
  logic par_q, par_d, tx_q, tx_d, bit_end, clr, last_stop;
  // timer restarts on every state entry and stays parked while no bit is on the line
  assign clr = state_d != state_q || state_q == S_IDLE || state_q == S_WAIT;
  assign last_stop = idx_q == 3'(STOP_BITS - 1);
  assign uart_tx = tx_q;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bit_end(bit_end)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = fifo.fifo_rd_en ? S_WAIT : S_IDLE;
      S_WAIT:   state_d = S_START;
      S_START:  state_d = bit_end ? S_DATA : S_START;
      S_DATA:   state_d = (bit_end && idx_q == 3'd7) ? (PARITY_EN ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY: state_d = bit_end ? S_STOP : S_PARITY;
      S_STOP:   state_d = (bit_end && last_stop) ? S_IDLE : S_STOP;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    fifo.fifo_rd_en = state_q == S_IDLE && tx_en && !fifo.fifo_empty && !rst;
    busy = state_q != S_IDLE;
    byte_done = state_q == S_STOP && bit_end && last_stop;
  end
  // line level is registered from the upcoming state so it changes on the entering edge
  always_comb begin
    sh_d = state_q == S_WAIT ? fifo.fifo_rd_data : (state_q == S_DATA && bit_end) ? sh_q >> 1 : sh_q;
    par_d = state_q == S_WAIT ? (^fifo.fifo_rd_data) ^ PARITY_ODD : par_q;
    idx_d = state_d != state_q ? 3'd0 : bit_end ? idx_q + 3'd1 : idx_q;
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : state_d == S_PARITY ? par_q : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_q  <= '0;
      par_q <= 1'b0;
      idx_q <= '0;
      tx_q  <= 1'b1;
    end else begin
      sh_q  <= sh_d;
      par_q <= par_d;
      idx_q <= idx_d;
      tx_q  <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: directed frame checks on four drain configurations with 1-cycle FIFO models
module tb_uart_tx_fifo_drain;
  logic clk = 1'b0;
  logic rst, tx_en;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt;
  logic [7:0] mem [4][16];
  int rp [4] = '{0, 0, 0, 0};
  int wp [4] = '{0, 0, 0, 0};
  logic [7:0] rdata [4];
  wire [3:0] tx, busy, done, rd;
  uart_tx_fifo_drain_if f0 ();
  uart_tx_fifo_drain_if f1 ();
  uart_tx_fifo_drain_if f2 ();
  uart_tx_fifo_drain_if f3 ();
  always #5 clk = ~clk;
  assign rd = {f3.fifo_rd_en, f2.fifo_rd_en, f1.fifo_rd_en, f0.fifo_rd_en};
  assign f0.fifo_empty = rp[0] == wp[0];
  assign f1.fifo_empty = rp[1] == wp[1];
  assign f2.fifo_empty = rp[2] == wp[2];
  assign f3.fifo_empty = rp[3] == wp[3];
  assign f0.fifo_rd_data = rdata[0];
  assign f1.fifo_rd_data = rdata[1];
  assign f2.fifo_rd_data = rdata[2];
  assign f3.fifo_rd_data = rdata[3];
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4)) d0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f0),
    .uart_tx(tx[0]), .busy(busy[0]), .byte_done(done[0])
  );
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1)) d1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f1),
    .uart_tx(tx[1]), .busy(busy[1]), .byte_done(done[1])
  );
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) d2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f2),
    .uart_tx(tx[2]), .busy(busy[2]), .byte_done(done[2])
  );
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f3),
    .uart_tx(tx[3]), .busy(busy[3]), .byte_done(done[3])
  );
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (rd[k]) begin
        rdata[k] <= mem[k][rp[k]];
        rp[k] <= rp[k] + 1;
      end
  task automatic push(input int k, input logic [7:0] b);
    mem[k][wp[k]] = b;
    wp[k] = wp[k] + 1;
  endtask
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // walks one frame cycle by cycle from the fifo_rd_en cycle; compares {rd_en, busy, tx, done}
  task automatic frame(input int k, input logic [7:0] b, input bit pe, input bit pb,
                       input int stops, input int drop_at, input int stop_at);
    int len;
    int bi;
    logic t;
    len = 2 + (9 + int'(pe) + stops) * 4;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      bi = (c - 2) / 4;
      t = c < 2 ? 1'b1 : bi == 0 ? 1'b0 : bi <= 8 ? b[bi-1] : (bi == 9 && pe) ? pb : 1'b1;
      check($sformatf("f%0d_%02h_c%0d", k, b, c), {28'd0, rd[k], busy[k], tx[k], done[k]},
            {28'd0, c == 0, c >= 1, t, c == len - 1});
      if (c == drop_at) tx_en = 1'b0;
      if (c == stop_at) return;
    end
  endtask
  initial begin
    rst = 1'b1;
    tx_en = 1'b1;
    push(0, 8'h55);
    repeat (2) @(posedge clk);
    #1 check("rst_state", {16'd0, rd, busy, tx, done}, {16'd0, 4'h0, 4'h0, 4'hF, 4'h0});
    @(posedge clk);
    #1 rst = 1'b0;
    frame(0, 8'h55, 0, 0, 1, -1, -1);
    @(posedge clk);
    #1 push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'hA3);
    frame(0, 8'h00, 0, 0, 1, -1, -1);
    frame(0, 8'hFF, 0, 0, 1, -1, -1);
    frame(0, 8'hA3, 0, 0, 1, -1, -1);
    @(posedge clk);
    #1 push(1, 8'h07);
    push(1, 8'h03);
    frame(1, 8'h07, 1, 1, 1, -1, -1);
    frame(1, 8'h03, 1, 0, 1, -1, -1);
    @(posedge clk);
    #1 push(2, 8'h03);
    frame(2, 8'h03, 1, 1, 1, -1, -1);
    @(posedge clk);
    #1 push(3, 8'h81);
    push(3, 8'h5A);
    frame(3, 8'h81, 0, 0, 2, -1, -1);
    frame(3, 8'h5A, 0, 0, 2, -1, -1);
    @(posedge clk);
    #1 tx_en = 1'b0;
    push(0, 8'h96);
    push(0, 8'h69);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd[0] || !tx[0]) cnt++;
    end
    check("txen_low_idle", cnt, 0);
    @(posedge clk);
    #1 tx_en = 1'b1;
    frame(0, 8'h96, 0, 0, 1, 19, -1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd != 4'h0) cnt++;
    end
    check("txen_drop_no_read", cnt, 0);
    check("fifo_left", wp[0] - rp[0], 1);
    @(posedge clk);
    #1 tx_en = 1'b1;
    frame(0, 8'h69, 0, 0, 1, -1, -1);
    @(posedge clk);
    #1 push(0, 8'hC3);
    push(0, 8'h3C);
    frame(0, 8'hC3, 0, 0, 1, -1, 27);
    #1 rst = 1'b1;
    #1 check("rst_async", {28'd0, rd[0], busy[0], tx[0], done[0]}, 32'h2);
    @(posedge clk);
    #1 rst = 1'b0;
    frame(0, 8'h3C, 0, 0, 1, -1, -1);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd != 4'h0 || tx != 4'hF) cnt++;
    end
    check("empty_no_read", cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the 2048x8 synchronous byte FIFO: pops bytes through the FIFO read port and serialises each one as an asynchronous UART frame on a single TX pin.
- Frame format: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO and the board UART pin, so any producer that fills the FIFO can stream bytes to a host.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal 4..65535.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  input  1  single system clock, shared with the FIFO.
- rst  input  1  asynchronous, active-high reset.
- tx_en  input  1  permits starting new frames; a frame in progress always completes.
- fifo_rd_en  output  1  FIFO read enable; one-cycle pulse per byte.
- fifo_rd_data  input  8  FIFO read data; valid the cycle after fifo_rd_en (no output register).
- fifo_empty  input  1  FIFO empty flag.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high whenever state is not IDLE.
- byte_done  output  1  one-cycle pulse when the final stop bit ends.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, uart_tx=1, fifo_rd_en=0, busy=0, byte_done=0, counters cleared. A byte in flight is lost.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_rd_en = tx_en & ~fifo_empty, combinational.
  - If fifo_rd_en is asserted, go to WAIT. Otherwise stay in IDLE.
- WAIT: one cycle. Latch fifo_rd_data into the shift register and compute parity. Go to START.
- START: uart_tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. Exit to PARITY if PARITY_EN, else to STOP.
- PARITY:
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = inverted XOR of the data bits.
  - Duration CLKS_PER_BIT cycles.
- STOP:
  - uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - byte_done is asserted in the last cycle, then go to IDLE.
- uart_tx is registered. It changes on the clock edge that enters each bit state.
- Latency: fifo_rd_en high in cycle 0 (IDLE) → uart_tx falls at the start of cycle 2.
- Frame length F = (9 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from START entry to STOP exit.
- Back-to-back frames: IDLE plus WAIT give a fixed 2-cycle idle-high gap, so consecutive fifo_rd_en pulses are F+2 cycles apart.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1. A bit ends when count = CLKS_PER_BIT-1.
  - Counter width is clog2(CLKS_PER_BIT).
  - Cleared on every state entry.
- Data bit index: 3-bit counter, 0..7.
- fifo_empty or tx_en changing mid-frame has no effect on the current frame.
- tx_en low in IDLE: no read, even if the FIFO is non-empty.
- fifo_rd_en is never asserted while fifo_empty=1 and never outside IDLE.
- Therefore no underflow and at most one outstanding read.

Decomposition:
- Package uart_pkg holds:
  - state encoding, localparams S_IDLE..S_STOP (3 bits);
  - UART_DATA_BITS=8;
  - the helper function for the bit-timer width (clog2).
- One sub-module: uart_bit_timer.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, clr. Output bit_end.
  - Instantiated once.
- The FSM, shift register and parity logic live in the top module.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO model with 1-cycle read latency):
1. Reset release, FIFO holds 0x55, tx_en=1 → single fifo_rd_en pulse at cycle 0. From cycle 2, uart_tx shows 0 (start) then 1,0,1,0,1,0,1,0 then 1, each held 4 cycles. byte_done pulses at cycle 41. busy is high cycles 1–41.
2. FIFO holds 0x00, 0xFF, 0xA3 → exactly three fifo_rd_en pulses, 42 cycles apart. Serial data decodes to 0x00, 0xFF, 0xA3. Each inter-frame gap is 2 cycles high.
3. PARITY_EN=1: PARITY_ODD=0 with 0x07 → parity bit 1; PARITY_ODD=1 with 0x03 → parity bit 1; PARITY_ODD=0 with 0x03 → parity bit 0. Frame is 44 cycles.
4. STOP_BITS=2, byte 0x81 → stop level high for 8 cycles, byte_done at the end of the 8th. Next start bit 2 cycles later.
5. tx_en=0 with a non-empty FIFO → no fifo_rd_en for 100 cycles and uart_tx stays 1. Raise tx_en, then drop it during data bit 3 → that frame completes and no further read occurs.
6. rst asserted during data bit 5 → same cycle, without waiting for a clock edge: uart_tx=1, busy=0, fifo_rd_en=0. After release with the FIFO holding 0x3C → a clean full frame of 0x3C. fifo_empty=1 throughout → fifo_rd_en never asserted.
